// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the character LCD driver.
package lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CLEAR    = 8'h01;  // clear display (slow)
  localparam logic [7:0] SET_CG   = 8'h40;  // CGRAM address base
  localparam logic [7:0] SET_DD   = 8'h80;  // DDRAM address base

  // Main sequencer states
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_CG_ADDR = 3'd2,
    ST_CG_DATA = 3'd3,
    ST_DD_ADDR = 3'd4,
    ST_DD_DATA = 3'd5
  } lcd_state_e;

  // Byte transmitter states
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2,
    TX_WAIT = 2'd3
  } tx_state_e;

  // DDRAM address of column 0 for a given display row
  function automatic logic [6:0] row_base(input logic [1:0] row, input int unsigned cols);
    logic [6:0] c;
    c = 7'(cols);
    case (row)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return c;
      default: return 7'h40 + c;
    endcase
  endfunction

  // Power-up command sequence, in transmit order
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Single-byte LCD bus transmitter: holds rs/data for the whole transaction,
// pulses lcd_en high for STEP_CYCLES then low for STEP_CYCLES, and optionally
// adds CLR_CYCLES of settle time (used after the clear-display command).
// Handshake: start_i is only honoured while busy_o is low; done_o pulses for
// one cycle when the transaction, including any long wait, has finished.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int STEP_CYCLES = 3000,
  parameter int CLR_CYCLES  = 150000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  input  logic       long_wait_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_dat_o
);

  localparam int CNT_MAX = (CLR_CYCLES > STEP_CYCLES) ? CLR_CYCLES : STEP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);

  tx_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic        long_q;
  logic        en_q;
  logic        rs_q;
  logic [7:0]  dat_q;
  logic        done_q;

  // Phase sequencer: latch byte at start, time the enable pulse and settle gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (start_i) begin
            rs_q    <= rs_i;
            dat_q   <= byte_i;
            long_q  <= long_wait_i;
            en_q    <= 1'b1;
            cnt_q   <= STEP_LAST;
            state_q <= TX_HIGH;
          end
        end
        TX_HIGH: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= STEP_LAST;
            state_q <= TX_LOW;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        TX_LOW: begin
          if (cnt_q == '0) begin
            if (long_q) begin
              cnt_q   <= CLR_LAST;
              state_q <= TX_WAIT;
            end else begin
              done_q  <= 1'b1;
              state_q <= TX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        TX_WAIT: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != TX_IDLE);
  assign done_o    = done_q;
  assign lcd_en_o  = en_q;
  assign lcd_rs_o  = rs_q;
  assign lcd_dat_o = dat_q;

endmodule

// File: rtl/lcd_char_driver.sv
// Character LCD driver: framebuffer + CGRAM shadow with per-entry dirty bits.
// Only dirty glyphs (first) and dirty cells are pushed to the panel; a tracked
// DDRAM cursor lets runs of adjacent cells on one row skip the address command.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int         ROWS        = 4,
  parameter int         COLS        = 20,
  parameter int         STEP_CYCLES = 3000,
  parameter int         CLR_CYCLES  = 150000,
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  localparam int        CELLS       = ROWS * COLS,
  localparam int        AW          = $clog2(CELLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          cg_wr_en,
  input  logic [5:0]    cg_addr,
  input  logic [4:0]    cg_data,
  output logic          init_done,
  output logic          idle,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_dat,
  output logic [2:0]    dbg_state_o
);

  // Buffers and dirty tracking
  logic [7:0]       fb_q [CELLS];
  logic [4:0]       cg_q [64];
  logic [CELLS-1:0] cell_dirty_q;
  logic [7:0]       glyph_dirty_q;

  // Sequencer registers
  lcd_state_e    state_q;
  logic [1:0]    init_idx_q;
  logic          pend_q;       // a byte has been issued and its done is awaited
  logic          tx_start_q;
  logic          tx_rs_q;
  logic [7:0]    tx_byte_q;
  logic          tx_long_q;
  logic [2:0]    glyph_q;
  logic [2:0]    row_q;
  logic [AW-1:0] cell_q;
  logic [6:0]    addr_q;
  logic [6:0]    cur_q;        // where the panel's DDRAM cursor currently points
  logic          cur_valid_q;
  logic          init_done_q;
  logic          idle_q;
  logic          idle_d;

  // Transmitter interface
  logic tx_busy;
  logic tx_done;

  // Scan results
  logic          wr_ok;
  logic          cg_any;
  logic [2:0]    cg_first;
  logic          dd_any;
  logic [AW-1:0] dd_first;
  logic [1:0]    tgt_row;
  logic [6:0]    tgt_col;
  logic [6:0]    tgt_addr;

  assign wr_ok = wr_en && (32'(wr_addr) < CELLS);

  // Upstream write port into the shadow buffers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) fb_q[i] <= FILL_CHAR;
      for (int i = 0; i < 64; i++) cg_q[i] <= 5'd0;
    end else begin
      if (wr_ok) fb_q[wr_addr] <= wr_data;
      if (cg_wr_en) cg_q[cg_addr] <= cg_data;
    end
  end

  // Lowest-index dirty glyph and cell, plus the DDRAM address of that cell
  always_comb begin
    cg_any   = |glyph_dirty_q;
    cg_first = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (glyph_dirty_q[i]) cg_first = 3'(i);
    end
    dd_any   = |cell_dirty_q;
    dd_first = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (cell_dirty_q[i]) dd_first = AW'(i);
    end
    tgt_row  = 2'(32'(dd_first) / COLS);
    tgt_col  = 7'(32'(dd_first) % COLS);
    tgt_addr = row_base(tgt_row, COLS) + tgt_col;
  end

  // Idle only when fully drained and no write arrived this cycle
  always_comb begin
    idle_d = init_done_q && (state_q == ST_SCAN) && !cg_any && !dd_any &&
             !tx_busy && !pend_q && !tx_start_q && !wr_ok && !cg_wr_en;
  end

  // Main sequencer: init, scan for dirty entries, emit command/data bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_idx_q    <= 2'd0;
      pend_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_rs_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      tx_long_q     <= 1'b0;
      glyph_q       <= 3'd0;
      row_q         <= 3'd0;
      cell_q        <= '0;
      addr_q        <= 7'd0;
      cur_q         <= 7'd0;
      cur_valid_q   <= 1'b0;
      init_done_q   <= 1'b0;
      idle_q        <= 1'b0;
      cell_dirty_q  <= '1;
      glyph_dirty_q <= '1;
    end else begin
      tx_start_q <= 1'b0;
      idle_q     <= idle_d;
      case (state_q)
        ST_INIT: begin
          if (!pend_q) begin
            pend_q     <= 1'b1;
            tx_start_q <= 1'b1;
            tx_rs_q    <= 1'b0;
            tx_byte_q  <= init_cmd(init_idx_q);
            tx_long_q  <= (init_idx_q == 2'd3);
          end else if (tx_done) begin
            pend_q <= 1'b0;
            if (init_idx_q == 2'd3) begin
              init_done_q <= 1'b1;
              state_q     <= ST_SCAN;
            end else begin
              init_idx_q <= init_idx_q + 2'd1;
            end
          end
        end
        ST_SCAN: begin
          if (cg_any) begin
            glyph_q <= cg_first;
            state_q <= ST_CG_ADDR;
          end else if (dd_any) begin
            cell_q <= dd_first;
            addr_q <= tgt_addr;
            // Column 0 always re-addresses: the panel cursor does not wrap rows
            if (cur_valid_q && (cur_q == tgt_addr) && (tgt_col != 7'd0)) begin
              state_q <= ST_DD_DATA;
            end else begin
              state_q <= ST_DD_ADDR;
            end
          end
        end
        ST_CG_ADDR: begin
          if (!pend_q) begin
            pend_q     <= 1'b1;
            tx_start_q <= 1'b1;
            tx_rs_q    <= 1'b0;
            tx_byte_q  <= SET_CG | {2'b00, glyph_q, 3'b000};
            tx_long_q  <= 1'b0;
          end else if (tx_done) begin
            pend_q  <= 1'b0;
            row_q   <= 3'd0;
            state_q <= ST_CG_DATA;
          end
        end
        ST_CG_DATA: begin
          if (!pend_q) begin
            pend_q     <= 1'b1;
            tx_start_q <= 1'b1;
            tx_rs_q    <= 1'b1;
            tx_byte_q  <= {3'b000, cg_q[{glyph_q, row_q}]};
            tx_long_q  <= 1'b0;
            if (row_q == 3'd0) glyph_dirty_q[glyph_q] <= 1'b0;
          end else if (tx_done) begin
            pend_q <= 1'b0;
            if (row_q == 3'd7) begin
              cur_valid_q <= 1'b0;
              state_q     <= ST_SCAN;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end
        end
        ST_DD_ADDR: begin
          if (!pend_q) begin
            pend_q     <= 1'b1;
            tx_start_q <= 1'b1;
            tx_rs_q    <= 1'b0;
            tx_byte_q  <= SET_DD | {1'b0, addr_q};
            tx_long_q  <= 1'b0;
          end else if (tx_done) begin
            pend_q      <= 1'b0;
            cur_q       <= addr_q;
            cur_valid_q <= 1'b1;
            state_q     <= ST_DD_DATA;
          end
        end
        ST_DD_DATA: begin
          if (!pend_q) begin
            pend_q               <= 1'b1;
            tx_start_q           <= 1'b1;
            tx_rs_q              <= 1'b1;
            tx_byte_q            <= fb_q[cell_q];
            tx_long_q            <= 1'b0;
            cell_dirty_q[cell_q] <= 1'b0;
          end else if (tx_done) begin
            pend_q  <= 1'b0;
            cur_q   <= cur_q + 7'd1;
            state_q <= ST_SCAN;
          end
        end
        default: state_q <= ST_INIT;
      endcase
      // Writes land after the sequencer's clears so a same-cycle write re-dirties
      if (wr_ok) cell_dirty_q[wr_addr] <= 1'b1;
      if (cg_wr_en) glyph_dirty_q[cg_addr[5:3]] <= 1'b1;
    end
  end

  lcd_byte_tx #(
    .STEP_CYCLES(STEP_CYCLES),
    .CLR_CYCLES (CLR_CYCLES)
  ) u_tx (
    .clk        (clk),
    .reset      (reset),
    .start_i    (tx_start_q),
    .rs_i       (tx_rs_q),
    .byte_i     (tx_byte_q),
    .long_wait_i(tx_long_q),
    .busy_o     (tx_busy),
    .done_o     (tx_done),
    .lcd_en_o   (lcd_en),
    .lcd_rs_o   (lcd_rs),
    .lcd_dat_o  (lcd_dat)
  );

  assign init_done   = init_done_q;
  assign idle        = idle_q;
  assign lcd_rw      = 1'b0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: a bus monitor pops an expected-byte queue on every
// lcd_en rising edge and checks pulse width, bus stability and the clear gap.
module tb_lcd_char_driver;

  localparam int ROWS  = 4;
  localparam int COLS  = 20;
  localparam int STEP  = 4;
  localparam int CLRW  = 20;
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'h00;
  logic          cg_wr_en = 1'b0;
  logic [5:0]    cg_addr = 6'd0;
  logic [4:0]    cg_data = 5'd0;
  logic          init_done;
  logic          idle;
  logic          lcd_rs;
  logic          lcd_rw;
  logic          lcd_en;
  logic [7:0]    lcd_dat;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  // Monitor state
  logic       prev_en = 1'b0;
  int         high_cnt = 0;
  int         low_cnt = 0;
  logic       after_clear = 1'b0;
  logic [8:0] cur_byte = 9'd0;

  lcd_char_driver #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .STEP_CYCLES(STEP),
    .CLR_CYCLES (CLRW),
    .FILL_CHAR  (8'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cg_wr_en   (cg_wr_en),
    .cg_addr    (cg_addr),
    .cg_data    (cg_data),
    .init_done  (init_done),
    .idle       (idle),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_dat    (lcd_dat),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Bus monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_en     = 1'b0;
      high_cnt    = 0;
      low_cnt     = 0;
      after_clear = 1'b0;
    end else begin
      if (lcd_en && !prev_en) begin
        cur_byte = {lcd_rs, lcd_dat};
        high_cnt = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got rs=%b dat=%h, required no byte", lcd_rs, lcd_dat);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if (cur_byte !== e) begin
            errors++;
            $display("FAIL bus_byte: got rs=%b dat=%h, required rs=%b dat=%h",
                     cur_byte[8], cur_byte[7:0], e[8], e[7:0]);
          end
        end
        if (after_clear) begin
          checks++;
          if (low_cnt < STEP + CLRW) begin
            errors++;
            $display("FAIL clear_gap: got %0d low cycles, required >= %0d", low_cnt, STEP + CLRW);
          end
          after_clear = 1'b0;
        end
      end else if (lcd_en) begin
        high_cnt++;
        checks++;
        if ({lcd_rs, lcd_dat} !== cur_byte) begin
          errors++;
          $display("FAIL bus_stable: got rs=%b dat=%h, required rs=%b dat=%h",
                   lcd_rs, lcd_dat, cur_byte[8], cur_byte[7:0]);
        end
      end else if (prev_en) begin
        checks++;
        if (high_cnt != STEP) begin
          errors++;
          $display("FAIL en_width: got %0d high cycles, required %0d", high_cnt, STEP);
        end
        low_cnt     = 1;
        after_clear = (cur_byte == {1'b0, 8'h01});
      end else begin
        low_cnt++;
      end
      prev_en = lcd_en;
    end
  end

  task automatic push(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d});
  endtask

  task automatic push_init();
    int bases[4];
    bases = '{0, 'h40, COLS, 'h40 + COLS};
    push(1'b0, 8'h38);
    push(1'b0, 8'h0C);
    push(1'b0, 8'h06);
    push(1'b0, 8'h01);
    for (int g = 0; g < 8; g++) begin
      push(1'b0, 8'(8'h40 + g * 8));
      for (int r = 0; r < 8; r++) push(1'b1, 8'h00);
    end
    for (int r = 0; r < ROWS; r++) begin
      push(1'b0, 8'(8'h80 + bases[r]));
      for (int c = 0; c < COLS; c++) push(1'b1, 8'h20);
    end
  endtask

  task automatic write_cell(input int addr, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: got idle=%b after %0d cycles, required 1", name, idle, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_en_high(input string name, input logic need_rs);
    int n;
    n = 0;
    while (!(lcd_en === 1'b1 && lcd_rs === need_rs) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(lcd_en === 1'b1 && lcd_rs === need_rs)) begin
      errors++;
      $display("FAIL %s_wait: got lcd_en=%b lcd_rs=%b, required 1/%b", name, lcd_en, lcd_rs, need_rs);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_dat, init_done, idle} !== 13'd0) begin
      errors++;
      $display("FAIL %s: got en=%b rs=%b rw=%b dat=%h init_done=%b idle=%b, required all 0",
               name, lcd_en, lcd_rs, lcd_rw, lcd_dat, init_done, idle);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    push_init();
    reset = 1'b0;
    wait_idle("init", 8000);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got %b, required 1", init_done);
    end
  endtask

  task automatic test_single_cell();
    push(1'b0, 8'h99);
    push(1'b1, 8'h41);
    write_cell(45, 8'h41);
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_drop: got idle=%b, required 0", idle);
    end
    wait_idle("single", 500);
  endtask

  task automatic test_out_of_range();
    write_cell(CELLS + 7, 8'h55);
    repeat (30) @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL oob_idle: got idle=%b, required 1", idle);
    end
  endtask

  task automatic test_contiguous();
    logic [7:0] d[3];
    for (int i = 0; i < 3; i++) d[i] = 8'($urandom_range(8'h21, 8'h7E));
    push(1'b0, 8'h80);
    for (int i = 0; i < 3; i++) push(1'b1, d[i]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = d[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("contiguous", 500);
  endtask

  task automatic test_glyph();
    push(1'b0, 8'h58);
    for (int r = 0; r < 8; r++) push(1'b1, 8'h1F);
    push(1'b0, 8'h83);
    push(1'b1, 8'h2A);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      cg_wr_en = 1'b1;
      cg_addr  = {3'd3, 3'(r)};
      cg_data  = 5'h1F;
      wr_en    = (r == 0);
      wr_addr  = AW'(3);
      wr_data  = 8'h2A;
    end
    @(negedge clk);
    cg_wr_en = 1'b0;
    wr_en    = 1'b0;
    wait_idle("glyph", 800);
  endtask

  task automatic test_rewrite();
    push(1'b0, 8'h80);
    push(1'b1, 8'h41);
    push(1'b0, 8'h80);
    push(1'b1, 8'h42);
    write_cell(0, 8'h41);
    wait_en_high("rewrite", 1'b1);
    write_cell(0, 8'h42);
    wait_idle("rewrite", 800);
  endtask

  task automatic test_reset_mid();
    push(1'b0, 8'h8A);
    push(1'b1, 8'h5A);
    write_cell(10, 8'h5A);
    wait_en_high("reset_mid", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (lcd_en !== 1'b0 || init_done !== 1'b0 || idle !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got en=%b init_done=%b idle=%b, required 0/0/0",
               lcd_en, init_done, idle);
    end
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("reset_mid_outputs");
    push_init();
    reset = 1'b0;
    wait_idle("reinit", 8000);
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_out_of_range();
    test_contiguous();
    test_glyph();
    test_rewrite();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
